// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the pipelined data memory.
// Holds the RISC-V load/store funct3 codes, the request bundle, the
// latency-pipe metadata record and the load lane-select/extension helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request addresses are normalised to this width before use.
  localparam int REQ_ADDR_W = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic                  we;
    logic [2:0]            funct3;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } mem_req_t;

  // One entry of the load latency pipe.
  typedef struct packed {
    logic       vld;
    logic [2:0] funct3;
    logic [1:0] addrLo;
    logic       err;
  } lat_meta_t;

  // True when funct3 is a defined encoding for the given direction.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    if (we) begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    return ok;
  endfunction

  // Picks the addressed lane out of a full word and sign/zero extends it.
  // Halfwords use addr_lo[1] only; a word ignores addr_lo entirely.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input logic [2:0]  funct3);
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] res;
    case (addr_lo)
      2'd0:    laneByte = word[7:0];
      2'd1:    laneByte = word[15:8];
      2'd2:    laneByte = word[23:16];
      default: laneByte = word[31:24];
    endcase
    laneHalf = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    res = {{24{laneByte[7]}}, laneByte};
      F3_H:    res = {{16{laneHalf[15]}}, laneHalf};
      F3_W:    res = word;
      F3_BU:   res = {24'h000000, laneByte};
      F3_HU:   res = {16'h0000, laneHalf};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 storage with a byte-strobe write port and a
// registered read port. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [3:0]       i_wstrb,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Write only the byte lanes whose strobe is set.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < 4; l++) begin
        if (i_wstrb[l]) begin
          r_mem[i_widx][8*l +: 8] <= i_wdata[8*l +: 8];
        end
      end
    end
  end

  // Capture the addressed word at the edge that accepts a load.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_ridx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe: pipelined MEM-stage data memory with a valid/ready request side,
// funct3-coded byte/half/word access, sign/zero extension and a fixed
// READ_LATENCY (1..4) load response. DEPTH_WORDS must be a power of two >= 4.
// Build option: define DMEM_MISALIGN_TRAP_EN to flag misaligned halfword/word
// accesses (no write, load returns 0 with err); otherwise low address bits
// below the access size are ignored.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 64,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_req_t    w_req;
  logic        w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]  w_addrLo;
  logic        w_legal;
  logic        w_misalign;
  logic        w_err;
  logic        w_storeEn;
  logic        w_loadEn;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wlanes;
  logic [31:0] w_arrRdata;
  logic [31:0] w_finalWord;
  logic [31:0] w_extended;
  logic        w_unusedAddr;
  lat_meta_t   w_final;

  ctrl_state_t r_state;
  ctrl_state_t w_nextState;
  lat_meta_t   r_meta [READ_LATENCY];
  logic [31:0] r_holdRdata;
  logic        r_holdErr;

  assign w_req = '{we:     req_we,
                   funct3: req_funct3,
                   addr:   REQ_ADDR_W'(req_addr),
                   wdata:  req_wdata};

  // Only the word index and lane bits matter; upper bits wrap the address.
  assign w_unusedAddr = ^w_req.addr;

  assign w_accept = req_valid && req_ready;
  assign w_idx    = w_req.addr[IDX_W+1:2];
  assign w_addrLo = w_req.addr[1:0];
  assign w_legal  = funct3_legal(w_req.we, w_req.funct3);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = ((w_req.funct3[1:0] == 2'b01) && w_addrLo[0]) ||
                      ((w_req.funct3[1:0] == 2'b10) && (w_addrLo != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err     = !w_legal || w_misalign;
  assign w_storeEn = w_accept && w_req.we && !w_err;
  assign w_loadEn  = w_accept && !w_req.we;

  // INIT/RUN state register; reset parks the block in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // INIT lasts exactly one cycle after reset, then RUN accepts forever.
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    case (r_state)
      ST_INIT: w_nextState = ST_RUN;
      ST_RUN:  req_ready   = 1'b1;
      default: w_nextState = ST_INIT;
    endcase
  end

  // Store strobes and lane-replicated write data from size and address.
  always_comb begin
    w_wstrb  = 4'b0000;
    w_wlanes = w_req.wdata;
    case (w_req.funct3[1:0])
      2'b00: begin
        w_wstrb  = 4'b0001 << w_addrLo;
        w_wlanes = {4{w_req.wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb  = w_addrLo[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_req.wdata[15:0]}};
      end
      2'b10: begin
        w_wstrb = 4'b1111;
      end
      default: w_wstrb = 4'b0000;
    endcase
  end

  // Stores land at their accept edge and the array samples a load at its own
  // accept edge, so a load one cycle behind a store to the same word already
  // reads the merged lanes.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clk  (clk),
    .i_we   (w_storeEn),
    .i_widx (w_idx),
    .i_wstrb(w_wstrb),
    .i_wdata(w_wlanes),
    .i_re   (w_loadEn),
    .i_ridx (w_idx),
    .o_rdata(w_arrRdata)
  );

  // Latency pipe for load metadata; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_meta[k] <= '0;
      end
    end else begin
      r_meta[0] <= '{vld:    w_loadEn,
                     funct3: w_req.funct3,
                     addrLo: w_addrLo,
                     err:    w_err};
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_meta[k] <= r_meta[k-1];
      end
    end
  end

  generate
    if (READ_LATENCY > 1) begin : g_dataDly
      logic [31:0] r_dataDly [READ_LATENCY-1];

      // Delay the raw array word alongside its metadata.
      always_ff @(posedge clk) begin
        r_dataDly[0] <= w_arrRdata;
        for (int k = 1; k < READ_LATENCY-1; k++) begin
          r_dataDly[k] <= r_dataDly[k-1];
        end
      end

      assign w_finalWord = r_dataDly[READ_LATENCY-2];
    end else begin : g_noDly
      assign w_finalWord = w_arrRdata;
    end
  endgenerate

  assign w_final    = r_meta[READ_LATENCY-1];
  assign w_extended = w_final.err ? 32'h0000_0000
                                  : load_extend(w_finalWord, w_final.addrLo, w_final.funct3);

  // Remember the last response so the outputs hold between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_holdRdata <= 32'h0000_0000;
      r_holdErr   <= 1'b0;
    end else if (w_final.vld) begin
      r_holdRdata <= w_extended;
      r_holdErr   <= w_final.err;
    end
  end

  assign rsp_valid = w_final.vld;
  assign rsp_rdata = w_final.vld ? w_extended  : r_holdRdata;
  assign rsp_err   = w_final.vld ? w_final.err : r_holdErr;

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: self-checking bench for dmem_pipe (DEPTH_WORDS=64,
// READ_LATENCY=2). A byte-level memory model and an expected-response queue
// are checked every cycle; directed sequences pin literal values.
// Honours DMEM_MISALIGN_TRAP_EN when the build defines it.
module tb_dmem_pipe;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int AW    = 32;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_pipe #(
    .DEPTH_WORDS (DEPTH),
    .READ_LATENCY(LAT),
    .ADDR_W      (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } log_t;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cycle       = 0;
  int          relCnt      = 0;
  int          lastDriveCyc;
  logic [31:0] mdlMem [DEPTH];
  exp_t        expQ[$];
  log_t        rspLog[$];
  logic [31:0] lastData = 32'h0;
  logic        lastErr  = 1'b0;
  exp_t        monExp;
  log_t        monLog;
  bit          monExpValid;
  bit          monExpReady;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Edges seen since reset release; the block is ready from the second cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) relCnt = 0;
    else if (relCnt < 2) relCnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference load: size from funct3[1:0], signedness from funct3[2].
  function automatic exp_t modelLoad(input logic [2:0] f3, input logic [31:0] addr);
    exp_t   r;
    int     idx;
    int     lo;
    int     size;
    int     off;
    bit     isSigned;
    longint v;
    logic [63:0] w;
    r.due  = 0;
    r.data = 32'h0;
    r.err  = 1'b0;
    idx = int'((addr >> 2) % DEPTH);
    lo  = int'(addr % 4);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      r.err = 1'b1;
      return r;
    end
    size     = 1 << f3[1:0];
    isSigned = (f3[2] == 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((lo % size) != 0) begin
      r.err = 1'b1;
      return r;
    end
`endif
    w = {32'h0, mdlMem[idx]};
    if (size == 4) begin
      v = longint'(w);
    end else begin
      off = (lo / size) * size;
      v = longint'((w >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1));
      if (isSigned && (v >= longint'(64'd1 << (8 * size - 1))))
        v = v - longint'(64'd1 << (8 * size));
    end
    r.data = v[31:0];
    return r;
  endfunction

  // Reference store: illegal or (when trapping) misaligned stores do nothing.
  task automatic modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int idx;
    int lo;
    int size;
    int off;
    idx = int'((addr >> 2) % DEPTH);
    lo  = int'(addr % 4);
    if (f3 > 3'd2) return;
    size = 1 << f3[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((lo % size) != 0) return;
`endif
    off = (lo / size) * size;
    for (int b = 0; b < size; b++) begin
      mdlMem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
    end
  endtask

  // Per-cycle compare against the model, then apply this cycle's accept.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_req_ready", req_ready, 0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 0);
      checkOutput("reset_rsp_err", rsp_err, 0);
      expQ.delete();
      lastData = 32'h0;
      lastErr  = 1'b0;
    end else begin
      monExpReady = (relCnt >= 1);
      checkOutput("req_ready", req_ready, monExpReady);
      monExpValid = (expQ.size() > 0) && (expQ[0].due == cycle);
      checkOutput("rsp_valid", rsp_valid, monExpValid);
      if (monExpValid) begin
        monExp   = expQ.pop_front();
        lastData = monExp.data;
        lastErr  = monExp.err;
      end
      checkOutput("rsp_rdata", rsp_rdata, lastData);
      checkOutput("rsp_err", rsp_err, lastErr);
      if (rsp_valid) begin
        monLog.cyc  = cycle;
        monLog.data = rsp_rdata;
        monLog.err  = rsp_err;
        rspLog.push_back(monLog);
      end
      if (req_valid && monExpReady) begin
        if (req_we) begin
          modelStore(req_funct3, req_addr, req_wdata);
        end else begin
          monExp     = modelLoad(req_funct3, req_addr);
          monExp.due = cycle + LAT;
          expQ.push_back(monExp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    req_valid    = 1'b1;
    req_we       = we;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wd;
    lastDriveCyc = cycle;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic checkLog(input int k, input string name, input logic [31:0] expD, input logic expE);
    if (rspLog.size() > k) begin
      checkOutput(name, rspLog[k].data, expD);
      checkOutput({name, "_err"}, {31'h0, rspLog[k].err}, {31'h0, expE});
    end else begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: got no response, expected response #%0d", name, k);
    end
  endtask

  task automatic checkLatency(input int k, input string name, input int acc);
    if (rspLog.size() > k) begin
      checkOutput(name, 32'(rspLog[k].cyc - acc), LAT);
    end else begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: got no response, expected one %0d cycles after accept", name, LAT);
    end
  endtask

  // Hard stop in case something wedges the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accLb;
    int accLh;
    int resetCyc;
    int late;
    logic [2:0] f3;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("init_ready_low", req_ready, 0);
    checkOutput("init_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    checkOutput("run_ready_high", req_ready, 1);

    // Fill every word so all later loads have known data.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 3'b010, 32'(i * 4), $urandom);
    end

    // Word store then byte/halfword loads of its upper lanes.
    rspLog.delete();
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
    accLb = lastDriveCyc;
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0);
    accLh = lastDriveCyc;
    idleCycle();
    repeat (LAT + 3) @(posedge clk);
    checkLog(0, "lb_0x13", 32'hFFFFFFDE, 1'b0);
    checkLog(1, "lbu_0x13", 32'h000000DE, 1'b0);
    checkLog(2, "lh_0x12", 32'hFFFFDEAD, 1'b0);
    checkLatency(0, "lb_latency", accLb);
    checkLatency(2, "lh_latency", accLh);

    // Byte store followed immediately by a word load of the same word.
    rspLog.delete();
    applyStimulus(1'b1, 3'b010, 32'h20, 32'h11223344);
    applyStimulus(1'b1, 3'b000, 32'h21, 32'h00000055);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0);
    idleCycle();
    repeat (LAT + 3) @(posedge clk);
    checkLog(0, "raw_sb_lw", 32'h11225544, 1'b0);

    // Misaligned word load, illegal store, illegal load.
    rspLog.delete();
    applyStimulus(1'b1, 3'b010, 32'h00, 32'hCAFEF00D);
    applyStimulus(1'b0, 3'b010, 32'h02, 32'h0);
    applyStimulus(1'b1, 3'b011, 32'h00, 32'h12345678);
    applyStimulus(1'b0, 3'b010, 32'h00, 32'h0);
    applyStimulus(1'b0, 3'b110, 32'h04, 32'h0);
    idleCycle();
    repeat (LAT + 3) @(posedge clk);
`ifdef DMEM_MISALIGN_TRAP_EN
    checkLog(0, "lw_misaligned", 32'h00000000, 1'b1);
`else
    checkLog(0, "lw_misaligned", 32'hCAFEF00D, 1'b0);
`endif
    checkLog(1, "illegal_store_noop", 32'hCAFEF00D, 1'b0);
    checkLog(2, "illegal_load", 32'h00000000, 1'b1);

    // Address wrap: 0x100 aliases word 0 with 64 words.
    rspLog.delete();
    applyStimulus(1'b1, 3'b010, 32'h100, 32'hA5A5A5A5);
    applyStimulus(1'b0, 3'b010, 32'h000, 32'h0);
    idleCycle();
    repeat (LAT + 3) @(posedge clk);
    checkLog(0, "wrap_lw", 32'hA5A5A5A5, 1'b0);

    // Four loads, then reset on the cycle after the last accept.
    rspLog.delete();
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h00, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    resetCyc  = cycle;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    repeat (LAT + 2) @(posedge clk);
    late = 0;
    foreach (rspLog[k]) if (rspLog[k].cyc >= resetCyc) late++;
    checkOutput("no_rsp_after_reset", late, 0);
    checkOutput("rsp_before_reset", rspLog.size(), 2);
    rspLog.delete();
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0);
    idleCycle();
    repeat (LAT + 3) @(posedge clk);
    checkLog(0, "mem_survives_reset_a", 32'hDEADBEEF, 1'b0);
    checkLog(1, "mem_survives_reset_b", 32'h11225544, 1'b0);

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        f3 = 3'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'b000;
          1:       f3 = 3'b001;
          2:       f3 = 3'b010;
          3:       f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      @(posedge clk);
      #1;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = f3;
      req_addr   = 32'($urandom_range(0, 511));
      req_wdata  = $urandom;
    end
    idleCycle();
    repeat (LAT + 4) @(posedge clk);
    checkOutput("drain_pending", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
Parametrised, pipelined successor to the single-cycle data memory. It replaces the combinational read with a synchronous read of configurable latency and a valid/ready request side. It adds RISC-V funct3-coded sign and zero extension, byte-strobe writes and misalignment detection. It sits in the MEM stage of the pipelined core, and the hazard unit uses rsp_valid to release load-use stalls.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; power of two, minimum 4.
READ_LATENCY, 1, cycles from request accept to rsp_valid; legal range 1..4.
ADDR_W, 32, width of the byte address input.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  a request is presented this cycle.
req_ready  out  1  the block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  access size and signedness, in RISC-V funct3 encoding.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned.
rsp_valid  out  1  load response is valid; single-cycle pulse per load.
rsp_rdata  out  32  extended load data.
rsp_err  out  1  the access was misaligned or used an illegal funct3.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high. Reset clears rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 and flushes every pipeline stage. Memory contents are not reset.
- Reset mid-operation: in-flight loads are dropped and produce no response.
- Init state: after reset deasserts, req_ready stays 0 for exactly one cycle (INIT), then goes to 1 (RUN) and remains 1.
- Accept: a request is accepted when req_valid && req_ready. One request may be accepted per cycle, with no bubbles.
- Word index: addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Store funct3 (req_we=1): 000 sb, 001 sh, 010 sw.
  - Byte lanes are selected by addr[1:0]. Only the addressed lanes are written, in the accept cycle.
  - Stores produce no rsp_valid.
- Load funct3 (req_we=0): 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Memory is read in the accept cycle.
  - Lane select and extension are applied in the final stage.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- Latency: a load accepted in cycle T gives rsp_valid=1 in cycle T+READ_LATENCY, carrying that load's rdata and err. Responses are returned in order, and there is no response backpressure.
- Read-after-write: when a store and a load are accepted in consecutive cycles to the same word, the load returns the post-store data, i.e. the written lanes merged with the old lanes.
- Illegal funct3 (store 011..111; load 011, 110, 111):
  - No memory write takes place.
  - A load returns rdata=0 with err=1 at the normal latency.
  - A store is silently dropped.
- rsp_rdata and rsp_err hold their last value when rsp_valid=0.

Optional Feature:
Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - A misaligned store performs no write.
  - A misaligned load returns rdata=0, err=1.
- Not defined:
  - Low address bits below the access size are ignored: a halfword uses addr[1], a word uses addr[1:0]=00.
  - Misaligned accesses are never flagged; rsp_err only reports illegal funct3.

Decomposition:
- Package dmem_pkg holds:
  - the funct3 localparams (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101);
  - the typedef mem_req_t {we, funct3, addr, wdata};
  - the function load_extend(word, addr_lo, funct3).
- One sub-module, dmem_array: a DEPTH_WORDS x 32 array with a 4-bit byte-strobe write port and a registered read port.
- The top level contains the INIT/RUN FSM, the strobe generation, the latency shift register carrying {valid, funct3, addr_lo, err}, and the read-after-write bypass.

Test Plan:
- Assert reset, release it, and sample req_ready: req_ready=0 for one cycle after release, then 1. rsp_valid stays 0 throughout.
- sw 0xDEADBEEF at addr 0x10, then lb at 0x13, lbu at 0x13 and lh at 0x12. With READ_LATENCY=2 the responses must be:
  - 0xFFFFFFDE, 2 cycles after the lb is accepted;
  - 0x000000DE, 2 cycles after the lbu is accepted;
  - 0xFFFFDEAD, 2 cycles after the lh is accepted.
- Back-to-back: sb 0x55 to 0x21 in cycle T, then lw 0x20 in cycle T+1 with word 0x20 previously 0x11223344. The response must be 0x11225544.
- Issue lw at 0x02:
  - With DMEM_MISALIGN_TRAP_EN defined: rdata=0, err=1.
  - Without it: word 0 is returned, err=0.
  - A store funct3=011 leaves memory unchanged.
- With DEPTH_WORDS=64, sw 0xA5A5A5A5 to 0x100, then lw 0x000: the load returns 0xA5A5A5A5 (wrap-around).
- Issue 4 loads, then assert reset on the cycle after the last accept. No rsp_valid may appear after reset, and the stored memory data must survive.
